fetch_redirect_unit: RTL and testbench
======================================

Name: fetch_redirect_unit

Overview:
- Fetch-side consumer of the branch resolution signal `br_taken` produced by the branch condition unit in EX.
- Owns the architectural fetch PC and issues sequential instruction-memory requests over a req/gnt handshake.
- On a resolved taken branch or jump it redirects the PC to the target and squashes the wrong-path instructions in IF/ID and ID/EX.
- Also counts taken redirects for performance monitoring.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- FLUSH_CYCLES, 2, number of cycles `flush_o` is held after a redirect is applied (range 1..7).
- CNT_W, 16, width of the taken-redirect counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 resets).
- stall_i  in  1  backend stall; hold PC, no new request.
- br_valid_i  in  1  EX holds a resolved branch/jump this cycle.
- br_taken_i  in  1  resolution outcome from the branch condition unit.
- br_target_i  in  32  redirect target.
- imem_req_o  out  1  instruction fetch request.
- imem_addr_o  out  32  fetch address; stable while req=1 and gnt=0.
- imem_gnt_i  in  1  memory accepts the request this cycle.
- pc_o  out  32  PC of the instruction accepted this cycle (valid with `fetch_valid_o`).
- fetch_valid_o  out  1  one-cycle pulse per granted, non-squashed fetch.
- flush_o  out  1  squash IF/ID and ID/EX.
- misalign_o  out  1  one-cycle pulse: taken target with [1:0]!=0.
- taken_cnt_o  out  CNT_W  saturating count of applied redirects.

Behaviour:
- Reset (reset==0 at posedge) forces:
  - state=BOOT; pc=RESET_PC; imem_req_o=0, imem_addr_o=RESET_PC.
  - fetch_valid_o=0, flush_o=0, misalign_o=0, taken_cnt_o=0.
  - pending redirect cleared; flush counter=0.
- Reset asserted mid-request abandons the request (req drops the next cycle, no grant expected).
- States:
  - BOOT: one cycle, req=0; then FETCH.
  - FETCH: req=!stall_i unless a request is outstanding. An outstanding request stays asserted regardless of stall_i until granted (address stable).
  - FLUSH: flush_o=1 and counter decrements. req may run on the new path; fetch_valid_o is still generated. Go to FETCH when the counter reaches 0.
- Sequential advance: on grant with no redirect, pc <= pc+4, wrapping 32'hFFFF_FFFC -> 32'h0 (modulo 2^32). fetch_valid_o=1 and pc_o=granted address, one cycle after the grant.
- Redirect qualification: br_valid_i && br_taken_i, sampled in FETCH only. br_valid_i in BOOT or FLUSH is ignored, because EX holds bubbles.
- Aligned target, no request outstanding (req=0, or req=1 with gnt=1 the same cycle):
  - Next cycle: pc=target, imem_addr_o=target; enter FLUSH with counter=FLUSH_CYCLES; taken_cnt_o increments.
  - The same-cycle granted fetch is squashed: no fetch_valid_o for it.
- Aligned target, request outstanding without grant:
  - Target latched into the pending register; address unchanged.
  - Redirect is applied on the cycle after the grant, as above; that granted fetch is squashed.
- br_taken_i=0, or br_valid_i=0: no effect.
- Misaligned taken target ([1:0]!=0): misalign_o pulses the next cycle; no redirect, no flush, count unchanged.
- Redirect has priority over stall_i. A redirect while stalled updates pc and flush, and req stays 0 until stall_i drops.
- taken_cnt_o saturates at all-ones.
- Latency: redirect resolved at cycle N gives imem_addr_o=target at N+1, and flush_o high for cycles N+1..N+FLUSH_CYCLES.

Decomposition:
- Shared package `fetch_pkg`:
  - state enum {BOOT, FETCH, FLUSH}.
  - PC_STEP=4.
  - opcode constants `INSTR_B_OPCODE`=7'b1100011 and `INSTR_J_OPCODE`=7'b1101111, for bench stimulus.
- One natural sub-module: `flush_timer` (load / decrement / zero flag, width $clog2(FLUSH_CYCLES+1)).

Test Plan:
- Reset then free run, gnt=1 always: req rises cycle 2, pc_o sequence 0x0, 0x4, 0x8, 0xC; flush_o=0; taken_cnt_o=0.
- Taken branch at addr 0x10 with br_target_i=0x100, FLUSH_CYCLES=2: next cycle imem_addr_o=0x100; flush_o high exactly 2 cycles; taken_cnt_o=1; fetch_valid_o then reports 0x100, 0x104.
- Redirect while req outstanding (gnt=0 for 3 cycles at 0x20, target 0x200): imem_addr_o stays 0x20 until grant. The cycle after grant: addr=0x200 and flush begins; no fetch_valid_o for 0x20.
- Misaligned target 0x102 taken: misalign_o single pulse; PC continues sequentially; flush_o=0; count unchanged. Not-taken (br_taken_i=0, target 0x300): no change.
- Wrap and stall: start PC 0xFFFF_FFF8 via redirect; fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0. stall_i=1 for 4 cycles holds req=0 and pc. A redirect to 0x40 during the stall is applied, with req resuming at 0x40 after the stall.
- Reset mid-FLUSH (reset=0 one cycle): all outputs at reset values next cycle; taken_cnt_o=0; BOOT, then fetch from RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch redirect unit and its bench.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_STEP        = 32'd4;
    localparam logic [6:0]  INSTR_B_OPCODE = 7'b1100011;
    localparam logic [6:0]  INSTR_J_OPCODE = 7'b1101111;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/flush_timer.sv
// Down-counter that times the squash window after a fetch redirect.
module flush_timer #(
    parameter int unsigned CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o,
    output logic last_o
);

    localparam int unsigned W = $clog2(CYCLES + 1);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // Next count: load wins over decrement; never wraps below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = W'(CYCLES);
        end else if (dec_i && (cnt_q != {W{1'b0}})) begin
            cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == {W{1'b0}});
    assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch PC owner: sequential imem requests, taken-branch redirect with
// wrong-path squash, misalignment reporting and a taken-redirect counter.
module fetch_redirect_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             br_valid_i,
    input  logic             br_taken_i,
    input  logic [31:0]      br_target_i,
    output logic             imem_req_o,
    output logic [31:0]      imem_addr_o,
    input  logic             imem_gnt_i,
    output logic [31:0]      pc_o,
    output logic             fetch_valid_o,
    output logic             flush_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] taken_cnt_o
);

    fetch_state_e     state_d, state_q;
    logic [31:0]      pc_d, pc_q;
    logic [31:0]      pc_out_d, pc_out_q;
    logic [31:0]      pend_tgt_d, pend_tgt_q;
    logic             pend_vld_d, pend_vld_q;
    logic             req_d, req_q;
    logic             fv_d, fv_q;
    logic             flush_d, flush_q;
    logic             mis_d, mis_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    logic             granted_s;
    logic             outstanding_s;
    logic             br_hit_s;
    logic             tgt_ok_s;
    logic             apply_s;
    logic [31:0]      apply_tgt_s;
    logic             timer_load_s;
    logic             timer_dec_s;
    logic             timer_zero_s;
    logic             timer_last_s;

    flush_timer #(
        .CYCLES (FLUSH_CYCLES)
    ) u_flush_timer (
        .clk    (clk),
        .reset  (reset),
        .load_i (timer_load_s),
        .dec_i  (timer_dec_s),
        .zero_o (timer_zero_s),
        .last_o (timer_last_s)
    );

    assign granted_s     = req_q & imem_gnt_i;
    assign outstanding_s = req_q & ~imem_gnt_i;
    // EX only carries real branches while fetching; BOOT/FLUSH see bubbles.
    assign br_hit_s      = (state_q == ST_FETCH) & br_valid_i & br_taken_i;
    assign tgt_ok_s      = is_word_aligned(br_target_i);

    // Redirect selection: a fresh aligned target applies unless a request is
    // still waiting for grant, in which case it parks until that grant.
    always_comb begin
        apply_s     = 1'b0;
        apply_tgt_s = br_target_i;
        pend_vld_d  = pend_vld_q;
        pend_tgt_d  = pend_tgt_q;
        if (br_hit_s && tgt_ok_s && !outstanding_s) begin
            apply_s     = 1'b1;
            apply_tgt_s = br_target_i;
        end else if (br_hit_s && tgt_ok_s) begin
            pend_vld_d  = 1'b1;
            pend_tgt_d  = br_target_i;
        end else if (pend_vld_q && granted_s) begin
            apply_s     = 1'b1;
            apply_tgt_s = pend_tgt_q;
        end else begin
            apply_s     = 1'b0;
        end
        if (apply_s) begin
            pend_vld_d = 1'b0;
        end else begin
            pend_vld_d = pend_vld_d;
        end
    end

    // Next-state, PC and request logic.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_out_d     = pc_out_q;
        req_d        = req_q;
        fv_d         = 1'b0;
        mis_d        = br_hit_s & ~tgt_ok_s;
        cnt_d        = cnt_q;
        timer_load_s = 1'b0;
        timer_dec_s  = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
                req_d   = ~stall_i;
            end
            ST_FETCH, ST_FLUSH: begin
                if (state_q == ST_FLUSH) begin
                    timer_dec_s = 1'b1;
                    // A zero count in FLUSH is unreachable; leave rather than hang.
                    if (timer_last_s || timer_zero_s) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end else begin
                    state_d = ST_FETCH;
                end
                if (apply_s) begin
                    pc_d         = apply_tgt_s;
                    state_d      = ST_FLUSH;
                    timer_load_s = 1'b1;
                    req_d        = ~stall_i;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else if (granted_s) begin
                    fv_d     = 1'b1;
                    pc_out_d = pc_q;
                    pc_d     = pc_q + PC_STEP;
                    req_d    = ~stall_i;
                end else if (outstanding_s) begin
                    req_d = 1'b1;
                end else begin
                    req_d = ~stall_i;
                end
            end
            default: begin
                state_d = ST_BOOT;
                req_d   = 1'b0;
            end
        endcase
        flush_d = (state_d == ST_FLUSH);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            pc_out_q   <= RESET_PC;
            pend_tgt_q <= 32'h0000_0000;
            pend_vld_q <= 1'b0;
            req_q      <= 1'b0;
            fv_q       <= 1'b0;
            flush_q    <= 1'b0;
            mis_q      <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_out_q   <= pc_out_d;
            pend_tgt_q <= pend_tgt_d;
            pend_vld_q <= pend_vld_d;
            req_q      <= req_d;
            fv_q       <= fv_d;
            flush_q    <= flush_d;
            mis_q      <= mis_d;
            cnt_q      <= cnt_d;
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = pc_q;
    assign pc_o          = pc_out_q;
    assign fetch_valid_o = fv_q;
    assign flush_o       = flush_q;
    assign misalign_o    = mis_q;
    assign taken_cnt_o   = cnt_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed scenarios plus a randomized run against a cycle-level reference model.
module tb_fetch_redirect_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RESET_PC     = 32'h0000_0000;
    localparam int          FLUSH_CYCLES = 2;
    localparam int          CNT_W        = 16;

    logic             clk = 1'b0;
    logic             reset, stall_i, br_valid_i, br_taken_i, imem_gnt_i;
    logic [31:0]      br_target_i;
    logic             imem_req_o, fetch_valid_o, flush_o, misalign_o;
    logic [31:0]      imem_addr_o, pc_o;
    logic [CNT_W-1:0] taken_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what the outputs must show after the coming edge.
    logic        m_boot, m_req, m_fv, m_mis, m_pend_v;
    logic [31:0] m_pc, m_pco, m_pend;
    int          m_left, m_cnt;

    fetch_redirect_unit #(
        .RESET_PC(RESET_PC), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .br_valid_i(br_valid_i),
        .br_taken_i(br_taken_i), .br_target_i(br_target_i), .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i), .pc_o(pc_o),
        .fetch_valid_o(fetch_valid_o), .flush_o(flush_o), .misalign_o(misalign_o),
        .taken_cnt_o(taken_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        logic        granted, hit, ok, redirect;
        logic [31:0] tgt;
        if (!reset) begin
            m_boot = 1'b1; m_left = 0; m_pc = RESET_PC; m_req = 1'b0; m_pend_v = 1'b0;
            m_cnt = 0; m_fv = 1'b0; m_mis = 1'b0;
            return;
        end
        hit      = !m_boot && (m_left == 0) && br_valid_i && br_taken_i;
        ok       = (br_target_i % 4) == 0;
        granted  = m_req && imem_gnt_i;
        m_mis    = hit && !ok;
        m_fv     = 1'b0;
        redirect = 1'b0;
        tgt      = br_target_i;
        if (m_boot) begin
            m_boot = 1'b0;
            m_req  = !stall_i;
            return;
        end
        if (hit && ok && !(m_req && !imem_gnt_i)) redirect = 1'b1;
        else if (hit && ok) begin m_pend_v = 1'b1; m_pend = br_target_i; end
        else if (m_pend_v && granted) begin redirect = 1'b1; tgt = m_pend; end
        if (m_left > 0) m_left--;
        if (redirect) begin
            m_pc = tgt; m_left = FLUSH_CYCLES; m_pend_v = 1'b0; m_req = !stall_i;
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end else if (granted) begin
            m_fv = 1'b1; m_pco = m_pc; m_pc = m_pc + 32'd4; m_req = !stall_i;
        end else if (!m_req) begin
            m_req = !stall_i;
        end
    endtask

    task automatic drive_cycle(input logic rst_v, input logic stall_v, input logic bv_v,
                               input logic bt_v, input logic [31:0] tgt_v, input logic gnt_v);
        reset = rst_v; stall_i = stall_v; br_valid_i = bv_v; br_taken_i = bt_v;
        br_target_i = tgt_v; imem_gnt_i = gnt_v;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        n_tests++;
        if ({imem_req_o, fetch_valid_o, flush_o, misalign_o} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {imem_req_o, fetch_valid_o, flush_o, misalign_o});
        end
        n_tests++;
        if (imem_addr_o !== RESET_PC || taken_cnt_o !== 16'h0) begin
            n_fail++; $display("FAIL reset_addr_cnt: got %h/%h want %h/0", imem_addr_o, taken_cnt_o, RESET_PC);
        end
    endtask

    task automatic test_free_run();
        logic [31:0] exp_pc;
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        n_tests++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            n_fail++; $display("FAIL boot_req: got req=%b addr=%h want 1/0", imem_req_o, imem_addr_o);
        end
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            exp_pc = 32'(i) << 2;
            n_tests++;
            if (fetch_valid_o !== 1'b1 || pc_o !== exp_pc || flush_o !== 1'b0 || taken_cnt_o !== 16'h0) begin
                n_fail++; $display("FAIL free_run: got v=%b pc=%h fl=%b cnt=%h want 1/%h/0/0", fetch_valid_o, pc_o, flush_o, taken_cnt_o, exp_pc);
            end
        end
    endtask

    task automatic test_taken_branch();
        drive_cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b1);
        n_tests++;
        if (imem_addr_o !== 32'h100 || flush_o !== 1'b1 || taken_cnt_o !== 16'd1 || fetch_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL taken_apply: got addr=%h fl=%b cnt=%h v=%b want 100/1/1/0", imem_addr_o, flush_o, taken_cnt_o, fetch_valid_o);
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        n_tests++;
        if (flush_o !== 1'b1 || fetch_valid_o !== 1'b1 || pc_o !== 32'h100) begin
            n_fail++; $display("FAIL taken_flush2: got fl=%b v=%b pc=%h want 1/1/100", flush_o, fetch_valid_o, pc_o);
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        n_tests++;
        if (flush_o !== 1'b0 || fetch_valid_o !== 1'b1 || pc_o !== 32'h104) begin
            n_fail++; $display("FAIL taken_after: got fl=%b v=%b pc=%h want 0/1/104", flush_o, fetch_valid_o, pc_o);
        end
    endtask

    task automatic test_redirect_outstanding();
        drive_cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0020, 1'b1);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (imem_addr_o !== 32'h20 || imem_req_o !== 1'b1 || flush_o !== 1'b0) begin
                n_fail++; $display("FAIL pend_hold%0d: got addr=%h req=%b fl=%b want 20/1/0", i, imem_addr_o, imem_req_o, flush_o);
            end
            if (i < 2) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        n_tests++;
        if (imem_addr_o !== 32'h200 || flush_o !== 1'b1 || fetch_valid_o !== 1'b0 || taken_cnt_o !== 16'd3) begin
            n_fail++; $display("FAIL pend_apply: got addr=%h fl=%b v=%b cnt=%h want 200/1/0/3", imem_addr_o, flush_o, fetch_valid_o, taken_cnt_o);
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_misalign_nottaken();
        drive_cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0102, 1'b1);
        n_tests++;
        if (misalign_o !== 1'b1 || fetch_valid_o !== 1'b1 || pc_o !== 32'h208 || imem_addr_o !== 32'h20C ||
            flush_o !== 1'b0 || taken_cnt_o !== 16'd3) begin
            n_fail++; $display("FAIL misalign: got m=%b v=%b pc=%h addr=%h fl=%b cnt=%h want 1/1/208/20c/0/3", misalign_o, fetch_valid_o, pc_o, imem_addr_o, flush_o, taken_cnt_o);
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        n_tests++;
        if (misalign_o !== 1'b0 || imem_addr_o !== 32'h210) begin
            n_fail++; $display("FAIL misalign_pulse: got m=%b addr=%h want 0/210", misalign_o, imem_addr_o);
        end
        drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0300, 1'b1);
        n_tests++;
        if (imem_addr_o !== 32'h214 || pc_o !== 32'h210 || flush_o !== 1'b0 || taken_cnt_o !== 16'd3) begin
            n_fail++; $display("FAIL not_taken: got addr=%h pc=%h fl=%b cnt=%h want 214/210/0/3", imem_addr_o, pc_o, flush_o, taken_cnt_o);
        end
    endtask

    task automatic test_wrap_stall();
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'hFFFF_FFF8; exp_seq[1] = 32'hFFFF_FFFC; exp_seq[2] = 32'h0000_0000;
        drive_cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            n_tests++;
            if (fetch_valid_o !== 1'b1 || pc_o !== exp_seq[i]) begin
                n_fail++; $display("FAIL wrap%0d: got v=%b pc=%h want 1/%h", i, fetch_valid_o, pc_o, exp_seq[i]);
            end
        end
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        n_tests++;
        if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h8 || fetch_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL stall_hold: got req=%b addr=%h v=%b want 0/8/0", imem_req_o, imem_addr_o, fetch_valid_o);
        end
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 1'b0);
        n_tests++;
        if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h40 || flush_o !== 1'b1 || taken_cnt_o !== 16'd5) begin
            n_fail++; $display("FAIL stall_redirect: got req=%b addr=%h fl=%b cnt=%h want 0/40/1/5", imem_req_o, imem_addr_o, flush_o, taken_cnt_o);
        end
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        n_tests++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin
            n_fail++; $display("FAIL stall_resume: got req=%b addr=%h want 1/40", imem_req_o, imem_addr_o);
        end
    endtask

    task automatic test_reset_mid_flush();
        drive_cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0080, 1'b1);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        n_tests++;
        if ({imem_req_o, fetch_valid_o, flush_o, misalign_o} !== 4'b0000 || imem_addr_o !== RESET_PC || taken_cnt_o !== 16'h0) begin
            n_fail++; $display("FAIL mid_flush_reset: got flags=%b addr=%h cnt=%h want 0000/%h/0", {imem_req_o, fetch_valid_o, flush_o, misalign_o}, imem_addr_o, taken_cnt_o, RESET_PC);
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        n_tests++;
        if (fetch_valid_o !== 1'b1 || pc_o !== RESET_PC) begin
            n_fail++; $display("FAIL reboot_fetch: got v=%b pc=%h want 1/%h", fetch_valid_o, pc_o, RESET_PC);
        end
    endtask

    task automatic test_random();
        logic [6:0]  op;
        logic [31:0] tgt;
        logic        bt;
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            op  = ($urandom_range(0, 1) == 0) ? INSTR_B_OPCODE : INSTR_J_OPCODE;
            bt  = (op == INSTR_J_OPCODE) ? 1'b1 : 1'($urandom_range(0, 1));
            tgt = ($urandom & 32'hFFFF_FFF0) | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            drive_cycle(1'($urandom_range(0, 63) != 0), 1'($urandom_range(0, 3) == 0),
                        1'($urandom_range(0, 2) == 0), bt, tgt, 1'($urandom_range(0, 1)));
            n_tests++;
            if (imem_req_o !== m_req || imem_addr_o !== m_pc || fetch_valid_o !== m_fv ||
                flush_o !== (m_left > 0) || misalign_o !== m_mis || taken_cnt_o !== m_cnt[CNT_W-1:0] ||
                (m_fv && pc_o !== m_pco)) begin
                n_fail++;
                $display("FAIL random cyc %0d: got req=%b addr=%h v=%b pc=%h fl=%b m=%b cnt=%h want %b/%h/%b/%h/%b/%b/%h",
                         i, imem_req_o, imem_addr_o, fetch_valid_o, pc_o, flush_o, misalign_o, taken_cnt_o,
                         m_req, m_pc, m_fv, m_pco, (m_left > 0), m_mis, m_cnt[CNT_W-1:0]);
            end
        end
    endtask

    initial begin
        m_pco = 32'h0; m_pend = 32'h0;
        test_reset();
        test_free_run();
        test_taken_branch();
        test_redirect_outstanding();
        test_misalign_nottaken();
        test_wrap_stall();
        test_reset_mid_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
